// File: rtl/pipeline_control_unit_if.sv
// Opcode/hazard inputs and registered WB/MEM/EX control bundle at the ID->EX boundary.
interface pipeline_control_unit_if #(
  parameter int OP_CTR_BUS_SIZE = 6,
  parameter int OP_ALU_BUS_SIZE = 2
);
  logic [OP_CTR_BUS_SIZE-1:0] i_op;
  logic                       i_valid;
  logic                       i_stall;
  logic                       i_flush;

  logic                       o_wb_reg_write;
  logic                       o_wb_mem_to_reg;
  logic                       o_mem_branch;
  logic                       o_mem_branch_ne;
  logic                       o_mem_read;
  logic                       o_mem_write;
  logic                       o_ex_dest;
  logic                       o_ex_alu_src;
  logic [OP_ALU_BUS_SIZE-1:0] o_ex_alu_op;
  logic                       o_jump;
  logic                       o_valid;
  logic                       o_illegal;
  logic                       o_halt_pending;
  logic                       o_halted;

  modport master (
    output i_op, i_valid, i_stall, i_flush,
    input  o_wb_reg_write, o_wb_mem_to_reg, o_mem_branch, o_mem_branch_ne,
           o_mem_read, o_mem_write, o_ex_dest, o_ex_alu_src, o_ex_alu_op,
           o_jump, o_valid, o_illegal, o_halt_pending, o_halted
  );

  modport slave (
    input  i_op, i_valid, i_stall, i_flush,
    output o_wb_reg_write, o_wb_mem_to_reg, o_mem_branch, o_mem_branch_ne,
           o_mem_read, o_mem_write, o_ex_dest, o_ex_alu_src, o_ex_alu_op,
           o_jump, o_valid, o_illegal, o_halt_pending, o_halted
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// Registered main control for ID->EX: opcode decode, bubble insertion and HALT drain.
//   state   | meaning
//   S_RUN   | decode and issue, or bubble on flush/stall/invalid/illegal
//   S_DRAIN | bubbles while in-flight instructions retire; r_cnt counts down
//   S_HALTED| bubbles, o_halted high until reset
module pipeline_control_unit #(
  parameter int OP_CTR_BUS_SIZE = 6,
  parameter int OP_ALU_BUS_SIZE = 2,
  parameter int DRAIN_CYCLES    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  pipeline_control_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [OP_CTR_BUS_SIZE-1:0] OP_RTYPE = OP_CTR_BUS_SIZE'(6'b000000);
  localparam logic [OP_CTR_BUS_SIZE-1:0] OP_LW    = OP_CTR_BUS_SIZE'(6'b100011);
  localparam logic [OP_CTR_BUS_SIZE-1:0] OP_SW    = OP_CTR_BUS_SIZE'(6'b101011);
  localparam logic [OP_CTR_BUS_SIZE-1:0] OP_BEQ   = OP_CTR_BUS_SIZE'(6'b000100);
  localparam logic [OP_CTR_BUS_SIZE-1:0] OP_BNE   = OP_CTR_BUS_SIZE'(6'b000101);
  localparam logic [OP_CTR_BUS_SIZE-1:0] OP_ADDI  = OP_CTR_BUS_SIZE'(6'b001000);
  localparam logic [OP_CTR_BUS_SIZE-1:0] OP_J     = OP_CTR_BUS_SIZE'(6'b000010);
  localparam logic [OP_CTR_BUS_SIZE-1:0] OP_HALT  = OP_CTR_BUS_SIZE'(6'b111111);

  localparam logic [OP_ALU_BUS_SIZE-1:0] ALU_ADD    = OP_ALU_BUS_SIZE'(2'b00);
  localparam logic [OP_ALU_BUS_SIZE-1:0] ALU_SUB    = OP_ALU_BUS_SIZE'(2'b01);
  localparam logic [OP_ALU_BUS_SIZE-1:0] ALU_FUNCT  = OP_ALU_BUS_SIZE'(2'b10);
  localparam logic [OP_ALU_BUS_SIZE-1:0] ALU_ADDI   = OP_ALU_BUS_SIZE'(2'b11);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  typedef struct packed {
    logic                       reg_write;
    logic                       mem_to_reg;
    logic                       branch;
    logic                       branch_ne;
    logic                       mem_read;
    logic                       mem_write;
    logic                       ex_dest;
    logic                       alu_src;
    logic [OP_ALU_BUS_SIZE-1:0] alu_op;
    logic                       jump;
  } ctl_t;

  state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  ctl_t       r_ctl, w_ctl_nxt, w_dec;
  logic       r_valid, w_valid_nxt;
  logic       r_illegal, w_illegal_nxt;
  logic       r_halt_pending, r_halted;
  logic       w_known, w_is_halt;

  always_comb begin
    w_dec     = '0;
    w_known   = 1'b1;
    w_is_halt = 1'b0;
    case (bus.i_op)
      OP_RTYPE: begin
        w_dec.reg_write = 1'b1;
        w_dec.ex_dest   = 1'b1;
        w_dec.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        w_dec.reg_write  = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.mem_read   = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        w_dec.branch = 1'b1;
        w_dec.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        w_dec.branch    = 1'b1;
        w_dec.branch_ne = 1'b1;
        w_dec.alu_op    = ALU_SUB;
      end
      OP_ADDI: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = ALU_ADDI;
      end
      OP_J:    w_dec.jump = 1'b1;
      OP_HALT: w_is_halt  = 1'b1;
      default: w_known    = 1'b0;
    endcase
  end

  // Everything not explicitly issued below is a bubble.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ctl_nxt     = '0;
    w_valid_nxt   = 1'b0;
    w_illegal_nxt = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.i_flush || bus.i_stall || !bus.i_valid) begin
          w_state_nxt = S_RUN;
        end else if (w_is_halt) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
        end else if (!w_known) begin
          w_illegal_nxt = 1'b1;
        end else begin
          w_ctl_nxt   = w_dec;
          w_valid_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HALTED;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_RUN;
      r_cnt          <= '0;
      r_ctl          <= '0;
      r_valid        <= 1'b0;
      r_illegal      <= 1'b0;
      r_halt_pending <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_ctl          <= w_ctl_nxt;
      r_valid        <= w_valid_nxt;
      r_illegal      <= w_illegal_nxt;
      r_halt_pending <= (w_state_nxt == S_DRAIN);
      r_halted       <= (w_state_nxt == S_HALTED);
    end
  end

  assign bus.o_wb_reg_write  = r_ctl.reg_write;
  assign bus.o_wb_mem_to_reg = r_ctl.mem_to_reg;
  assign bus.o_mem_branch    = r_ctl.branch;
  assign bus.o_mem_branch_ne = r_ctl.branch_ne;
  assign bus.o_mem_read      = r_ctl.mem_read;
  assign bus.o_mem_write     = r_ctl.mem_write;
  assign bus.o_ex_dest       = r_ctl.ex_dest;
  assign bus.o_ex_alu_src    = r_ctl.alu_src;
  assign bus.o_ex_alu_op     = r_ctl.alu_op;
  assign bus.o_jump          = r_ctl.jump;
  assign bus.o_valid         = r_valid;
  assign bus.o_illegal       = r_illegal;
  assign bus.o_halt_pending  = r_halt_pending;
  assign bus.o_halted        = r_halted;

endmodule
